stall_control_unit: RTL and testbench
=====================================

STALL_CONTROL_UNIT -- requirements
Module: stall_control_unit

Interface
REQ-001 SHALL have port CLK  input  1  single system clock; all state updates on rising edge.
REQ-002 SHALL have port RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port MEM_READ_EX  input  1  instruction in EX is a load.
REQ-004 SHALL have port DEST_EX  input  5  destination register of EX instruction.
REQ-005 SHALL have port RS1_ID  input  5  source register 1 of ID instruction.
REQ-006 SHALL have port RS2_ID  input  5  source register 2 of ID instruction.
REQ-007 SHALL have port RS1_USED_ID  input  1  ID instruction reads RS1.
REQ-008 SHALL have port RS2_USED_ID  input  1  ID instruction reads RS2.
REQ-009 SHALL have port MULDIV_EX  input  1  valid M-extension op entering EX this cycle.
REQ-010 SHALL have port IS_DIV_EX  input  1  1 = DIV/DIVU/REM/REMU, 0 = MUL*.
REQ-011 SHALL have port FLUSH  input  1  taken branch/jump flush request.
REQ-012 SHALL have port PC_STALL  output  1  hold PC.
REQ-013 SHALL have port IFID_STALL  output  1  hold IF/ID register.
REQ-014 SHALL have port IDEX_BUBBLE  output  1  load NOP into ID/EX.
REQ-015 SHALL have port EX_HOLD  output  1  hold ID/EX and EX/MEM while M-op iterates.
REQ-016 SHALL have port MULDIV_DONE  output  1  one-cycle pulse: M-op result valid.
REQ-017 SHALL have port BUSY  output  1  state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD_STALL, MULDIV_WAIT, plus a 5-bit down-counter CNT.
REQ-019 SHALL register all outputs; outputs change only on rising CLK or on RESET assertion.
REQ-020 SHALL define load-use hit = MEM_READ_EX & DEST_EX!=0 & ((RS1_USED_ID & RS1_ID==DEST_EX) | (RS2_USED_ID & RS2_ID==DEST_EX)).
REQ-021 SHALL, in IDLE at an edge with load-use hit and MULDIV_EX=0, enter LOAD_STALL with PC_STALL=IFID_STALL=IDEX_BUBBLE=1.
REQ-022 SHALL leave LOAD_STALL to IDLE after exactly one cycle, ignoring the hit condition while in LOAD_STALL (stall length exactly 1 cycle per load).
REQ-023 SHALL, in IDLE at an edge with MULDIV_EX=1, enter MULDIV_WAIT, load CNT=2 (MUL) or CNT=31 (DIV), and assert PC_STALL=IFID_STALL=EX_HOLD=1, IDEX_BUBBLE=0.
REQ-024 SHALL decrement CNT at each edge in MULDIV_WAIT; at the edge where CNT==1, go to IDLE, drop all stall outputs, and pulse MULDIV_DONE=1 for that one cycle.
REQ-025 SHALL give MULDIV_EX priority over load-use hit when both are true in IDLE.
REQ-026 SHALL ignore MULDIV_EX and load-use hit while not in IDLE (no re-trigger, no counter reload).
REQ-027 SHALL, on FLUSH=1 in IDLE or LOAD_STALL, go to or stay in IDLE with all outputs 0 (FLUSH overrides a same-edge load-use hit).
REQ-028 SHALL ignore FLUSH in MULDIV_WAIT; the M-op completes.
REQ-029 SHALL drive BUSY=1 in LOAD_STALL and MULDIV_WAIT, 0 in IDLE.
REQ-030 SHALL never flag a hazard on DEST_EX==0 (x0).

Reset
REQ-031 SHALL, while RESET=0, immediately force state IDLE, CNT=0, and all outputs 0, independent of CLK.
REQ-032 SHALL abort any in-progress stall on reset without a MULDIV_DONE pulse; first evaluation occurs at the first rising edge after RESET returns to 1.

Verification
REQ-033 SHALL verify load-use: MEM_READ_EX=1, DEST_EX=5, RS2_ID=5, RS2_USED_ID=1 -> PC_STALL/IFID_STALL/IDEX_BUBBLE=1 for exactly 1 cycle, then 0.
REQ-034 SHALL verify no false hazards: DEST_EX=0 with RS1_ID=0; or RS1_ID=5 with RS1_USED_ID=0 -> no stall.
REQ-035 SHALL verify MUL: MULDIV_EX=1, IS_DIV_EX=0 -> EX_HOLD=1 for 2 cycles, then MULDIV_DONE=1 for 1 cycle.
REQ-036 SHALL verify DIV with FLUSH=1 and load-use hit asserted mid-wait -> stall held 31 cycles, CNT unaffected, single MULDIV_DONE.
REQ-037 SHALL verify simultaneous MULDIV_EX=1 and load-use hit -> MULDIV_WAIT entered, IDEX_BUBBLE stays 0.
REQ-038 SHALL verify RESET=0 at DIV cycle 10 -> all outputs 0 immediately; no MULDIV_DONE after release.

Source files
------------

// File: rtl/stall_control_unit.sv
// Pipeline stall controller: one-cycle load-use bubbles and multi-cycle M-extension holds.
// All outputs are registered and are derived from the state the FSM is entering.
module stall_control_unit (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       MEM_READ_EX,
    input  logic [4:0] DEST_EX,
    input  logic [4:0] RS1_ID,
    input  logic [4:0] RS2_ID,
    input  logic       RS1_USED_ID,
    input  logic       RS2_USED_ID,
    input  logic       MULDIV_EX,
    input  logic       IS_DIV_EX,
    input  logic       FLUSH,
    output logic       PC_STALL,
    output logic       IFID_STALL,
    output logic       IDEX_BUBBLE,
    output logic       EX_HOLD,
    output logic       MULDIV_DONE,
    output logic       BUSY
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOAD_STALL  = 2'd1,
        MULDIV_WAIT = 2'd2
    } state_t;

    localparam logic [4:0] MUL_CYCLES = 5'd2;
    localparam logic [4:0] DIV_CYCLES = 5'd31;

    state_t     state;
    state_t     state_next;
    logic [4:0] cnt;
    logic [4:0] cnt_next;

    logic pc_stall_next;
    logic ifid_stall_next;
    logic idex_bubble_next;
    logic ex_hold_next;
    logic muldiv_done_next;
    logic busy_next;

    logic rs1_match;
    logic rs2_match;
    logic load_use_hit;

    // x0 is never a real producer, so a zero destination can never cause a hazard
    assign rs1_match    = RS1_USED_ID && (RS1_ID == DEST_EX);
    assign rs2_match    = RS2_USED_ID && (RS2_ID == DEST_EX);
    assign load_use_hit = MEM_READ_EX && (DEST_EX != 5'd0) && (rs1_match || rs2_match);

    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        muldiv_done_next = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = 5'd0;
                if (FLUSH) begin
                    state_next = IDLE;
                end else if (MULDIV_EX) begin
                    state_next = MULDIV_WAIT;
                    cnt_next   = IS_DIV_EX ? DIV_CYCLES : MUL_CYCLES;
                end else if (load_use_hit) begin
                    state_next = LOAD_STALL;
                end
            end

            LOAD_STALL: begin
                state_next = IDLE;
                cnt_next   = 5'd0;
            end

            // Flush and new requests are deliberately ignored until the M-op retires
            MULDIV_WAIT: begin
                if (cnt <= 5'd1) begin
                    state_next       = IDLE;
                    cnt_next         = 5'd0;
                    muldiv_done_next = 1'b1;
                end else begin
                    cnt_next = cnt - 5'd1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = 5'd0;
            end
        endcase

        pc_stall_next    = (state_next != IDLE);
        ifid_stall_next  = (state_next != IDLE);
        idex_bubble_next = (state_next == LOAD_STALL);
        ex_hold_next     = (state_next == MULDIV_WAIT);
        busy_next        = (state_next != IDLE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= IDLE;
            cnt         <= 5'd0;
            PC_STALL    <= 1'b0;
            IFID_STALL  <= 1'b0;
            IDEX_BUBBLE <= 1'b0;
            EX_HOLD     <= 1'b0;
            MULDIV_DONE <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            PC_STALL    <= pc_stall_next;
            IFID_STALL  <= ifid_stall_next;
            IDEX_BUBBLE <= idex_bubble_next;
            EX_HOLD     <= ex_hold_next;
            MULDIV_DONE <= muldiv_done_next;
            BUSY        <= busy_next;
        end
    end

    // Structural invariants of the controller
    bubble_hold_exclusive: assert property (@(posedge CLK) disable iff (!RESET)
        !(IDEX_BUBBLE && EX_HOLD));

    done_only_when_idle: assert property (@(posedge CLK) disable iff (!RESET)
        MULDIV_DONE |-> !BUSY);

    wait_counter_nonzero: assert property (@(posedge CLK) disable iff (!RESET)
        (state == MULDIV_WAIT) |-> (cnt != 5'd0));

endmodule

// File: tb/tb_stall_control_unit.sv
// Self-checking bench for stall_control_unit: directed vector table, corner sequences,
// and randomized traffic compared against a cycle-count reference model.
module tb_stall_control_unit;

    logic       CLK;
    logic       RESET;
    logic       MEM_READ_EX;
    logic [4:0] DEST_EX;
    logic [4:0] RS1_ID;
    logic [4:0] RS2_ID;
    logic       RS1_USED_ID;
    logic       RS2_USED_ID;
    logic       MULDIV_EX;
    logic       IS_DIV_EX;
    logic       FLUSH;
    logic       PC_STALL;
    logic       IFID_STALL;
    logic       IDEX_BUBBLE;
    logic       EX_HOLD;
    logic       MULDIV_DONE;
    logic       BUSY;

    logic [5:0] dut_out;
    assign dut_out = {PC_STALL, IFID_STALL, IDEX_BUBBLE, EX_HOLD, MULDIV_DONE, BUSY};

    localparam logic [5:0] O_IDLE  = 6'b000000;
    localparam logic [5:0] O_STALL = 6'b111001;
    localparam logic [5:0] O_HOLD  = 6'b110101;
    localparam logic [5:0] O_DONE  = 6'b000010;

    int checks   = 0;
    int failures = 0;

    // Reference model: remaining M-op hold cycles, pending load bubble, done pulse
    int hold_left = 0;
    bit load_left = 0;
    bit done_now  = 0;

    typedef struct packed {
        logic       mr;
        logic [4:0] dest;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1u;
        logic       rs2u;
        logic       md;
        logic       dv;
        logic       fl;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[14];

    stall_control_unit dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .MEM_READ_EX (MEM_READ_EX),
        .DEST_EX     (DEST_EX),
        .RS1_ID      (RS1_ID),
        .RS2_ID      (RS2_ID),
        .RS1_USED_ID (RS1_USED_ID),
        .RS2_USED_ID (RS2_USED_ID),
        .MULDIV_EX   (MULDIV_EX),
        .IS_DIV_EX   (IS_DIV_EX),
        .FLUSH       (FLUSH),
        .PC_STALL    (PC_STALL),
        .IFID_STALL  (IFID_STALL),
        .IDEX_BUBBLE (IDEX_BUBBLE),
        .EX_HOLD     (EX_HOLD),
        .MULDIV_DONE (MULDIV_DONE),
        .BUSY        (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vec_t mk(logic mr, logic [4:0] dest, logic [4:0] rs1, logic [4:0] rs2,
                                logic rs1u, logic rs2u, logic md, logic dv, logic fl,
                                logic [5:0] exp);
        vec_t v;
        v.mr = mr; v.dest = dest; v.rs1 = rs1; v.rs2 = rs2;
        v.rs1u = rs1u; v.rs2u = rs2u; v.md = md; v.dv = dv; v.fl = fl; v.exp = exp;
        return v;
    endfunction

    function automatic bit ref_hit();
        bit src1, src2;
        src1 = RS1_USED_ID && (RS1_ID == DEST_EX);
        src2 = RS2_USED_ID && (RS2_ID == DEST_EX);
        return MEM_READ_EX && (DEST_EX != 0) && (src1 || src2);
    endfunction

    function automatic logic [5:0] model_out();
        bit stalled;
        stalled = (hold_left > 0) || load_left;
        return {stalled, stalled, load_left, (hold_left > 0), done_now, stalled};
    endfunction

    task automatic model_reset();
        hold_left = 0;
        load_left = 0;
        done_now  = 0;
    endtask

    task automatic model_step();
        if (hold_left > 0) begin
            hold_left = hold_left - 1;
            done_now  = (hold_left == 0);
        end else if (load_left) begin
            load_left = 0;
            done_now  = 0;
        end else begin
            done_now = 0;
            if (!FLUSH) begin
                if (MULDIV_EX) hold_left = IS_DIV_EX ? 31 : 2;
                else if (ref_hit()) load_left = 1;
            end
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        MEM_READ_EX = v.mr;
        DEST_EX     = v.dest;
        RS1_ID      = v.rs1;
        RS2_ID      = v.rs2;
        RS1_USED_ID = v.rs1u;
        RS2_USED_ID = v.rs2u;
        MULDIV_EX   = v.md;
        IS_DIV_EX   = v.dv;
        FLUSH       = v.fl;
    endtask

    task automatic check_output(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=%b expected=%b (pc,ifid,bubble,hold,done,busy) t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RESET = 1'b0;
        apply_stimulus(mk(1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 1, 1, O_IDLE));
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check_output("reset_state", dut_out, O_IDLE);
        apply_stimulus(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, O_IDLE));
        @(negedge CLK);
        RESET = 1'b1;

        vecs[0]  = mk(1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0, O_STALL);
        vecs[1]  = mk(1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0, O_IDLE);
        vecs[2]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, O_IDLE);
        vecs[3]  = mk(1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, O_IDLE);
        vecs[4]  = mk(1, 5'd5, 5'd5, 5'd3, 0, 1, 0, 0, 0, O_IDLE);
        vecs[5]  = mk(0, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0, O_IDLE);
        vecs[6]  = mk(1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 1, O_IDLE);
        vecs[7]  = mk(1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 0, 0, O_HOLD);
        vecs[8]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, O_HOLD);
        vecs[9]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, O_DONE);
        vecs[10] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, O_IDLE);
        vecs[11] = mk(1, 5'd7, 5'd7, 5'd1, 1, 0, 0, 0, 0, O_STALL);
        vecs[12] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, O_IDLE);
        vecs[13] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, O_IDLE);

        for (int i = 0; i < 14; i++) begin
            apply_stimulus(vecs[i]);
            tick();
            check_output($sformatf("vec%0d", i), dut_out, vecs[i].exp);
        end

        // DIV with flush, load-use hit and new M-op requests arriving mid-wait
        apply_stimulus(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, O_HOLD));
        tick();
        check_output("div_hold_1", dut_out, O_HOLD);
        for (int k = 2; k <= 31; k++) begin
            apply_stimulus(mk(1, 5'd9, 5'd9, 5'd9, 1, 1, (k % 5) == 0, (k % 2) == 0,
                              (k % 3) == 0, O_HOLD));
            tick();
            check_output($sformatf("div_hold_%0d", k), dut_out, O_HOLD);
        end
        apply_stimulus(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, O_IDLE));
        tick();
        check_output("div_done", dut_out, O_DONE);
        tick();
        check_output("div_after_done", dut_out, O_IDLE);

        // Asynchronous reset at DIV cycle 10, no done pulse afterwards
        apply_stimulus(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 0, O_HOLD));
        tick();
        apply_stimulus(mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, O_HOLD));
        for (int k = 2; k <= 10; k++) tick();
        check_output("div_cycle10_hold", dut_out, O_HOLD);
        #2;
        RESET = 1'b0;
        #1;
        check_output("async_reset", dut_out, O_IDLE);
        model_reset();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            check_output("post_reset_quiet", dut_out, model_out());
        end

        // Randomized traffic against the reference model
        for (int n = 0; n < 600; n++) begin
            MEM_READ_EX = 1'($urandom_range(0, 1));
            DEST_EX     = 5'($urandom_range(0, 3));
            RS1_ID      = 5'($urandom_range(0, 3));
            RS2_ID      = 5'($urandom_range(0, 3));
            RS1_USED_ID = ($urandom_range(0, 3) != 0);
            RS2_USED_ID = ($urandom_range(0, 3) != 0);
            FLUSH       = ($urandom_range(0, 9) == 0);
            MULDIV_EX   = !FLUSH && ($urandom_range(0, 11) == 0);
            IS_DIV_EX   = ($urandom_range(0, 3) == 0);
            tick();
            check_output("random", dut_out, model_out());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
